gpio_pin_filter12: RTL

- Per-pin input glitch/debounce filter between GPIO pads and the GPIO lite subunit pin input (pin_in12).
- Synchronises raw pad inputs, then accepts a level change only after it is stable for a programmable number of sample ticks.
- A shared prescaler generates the sample ticks; the filter is enabled per pin, and disabled pins pass through after synchronisation.

---
 rtl/gpio_pin_filter12_pkg.sv | 16 +
 rtl/gpio_pin_filter12_if.sv | 40 ++++
 rtl/gpio_pin_filter12_cell.sv | 99 +++++++++
 rtl/gpio_pin_filter12.sv | 67 ++++++
 4 files changed

// File: rtl/gpio_pin_filter12_pkg.sv
// Shared constants and helpers for the GPIO pin input filter.
// Latency: n/a (compile-time constants and a pure function).
// Backpressure: n/a.
package gpio_filter_pkg12;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_PRE_W = 16;

    // A zero threshold would never be reachable by cnt+1, so it is read as
    // "accept on the first tick".
    function automatic int unsigned eff_thr_f(input int unsigned thr);
        return (thr == 0) ? 1 : thr;
    endfunction

endpackage

// File: rtl/gpio_pin_filter12_if.sv
// Pad-side / config / filtered-pin bundle of the GPIO pin filter.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or strobe, no handshake.
// Optional glitch flag ports appear when GPIO_PIN_FILTER_GLITCH_FLAG_EN is defined.
interface gpio_pin_filter12_if
    import gpio_filter_pkg12::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
);
    logic [WIDTH-1:0] pad_in12;
    logic [WIDTH-1:0] filter_en12;
    logic [CNT_W-1:0] threshold12;
    logic [PRE_W-1:0] prescale12;
    logic [WIDTH-1:0] pin_filt12;
    logic             tick12;
`ifdef GPIO_PIN_FILTER_GLITCH_FLAG_EN
    logic             glitch_clr12;
    logic [WIDTH-1:0] glitch_seen12;

    modport master (
        output pad_in12, filter_en12, threshold12, prescale12, glitch_clr12,
        input  pin_filt12, tick12, glitch_seen12
    );
    modport slave (
        input  pad_in12, filter_en12, threshold12, prescale12, glitch_clr12,
        output pin_filt12, tick12, glitch_seen12
    );
`else
    modport master (
        output pad_in12, filter_en12, threshold12, prescale12,
        input  pin_filt12, tick12
    );
    modport slave (
        input  pad_in12, filter_en12, threshold12, prescale12,
        output pin_filt12, tick12
    );
`endif
endinterface

// File: rtl/gpio_pin_filter12_cell.sv
// One pin: 2-flop synchroniser, tick-counted stability filter, optional sticky glitch flag.
// Latency: 3 cycles pad to pin_o in bypass; filtered adds eff_thr sample ticks.
// Backpressure: none; the pin value is always presented. Glitch flag: GPIO_PIN_FILTER_GLITCH_FLAG_EN.
module gpio_pin_filter_cell12
    import gpio_filter_pkg12::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             pclk12,
    input  logic             n_reset12,
    input  logic             pad_i,
    input  logic             filt_en_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] eff_thr_i,
`ifdef GPIO_PIN_FILTER_GLITCH_FLAG_EN
    input  logic             glitch_clr_i,
    output logic             glitch_seen_o,
`endif
    output logic             pin_o
);
    logic             sync_a_q;
    logic             sync_b_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;

    // Two-stage synchroniser; only sync_b_q is trusted downstream.
    always_ff @(posedge pclk12 or negedge n_reset12) begin
        if (!n_reset12) begin
            sync_a_q <= 1'b0;
            sync_b_q <= 1'b0;
        end else begin
            sync_a_q <= pad_i;
            sync_b_q <= sync_a_q;
        end
    end

    // Accept a differing level only after eff_thr consecutive differing ticks;
    // any return to the stable level discards the partial count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
        if (!filt_en_i) begin
            stable_d = sync_b_q;
            cnt_d    = '0;
        end else if (sync_b_q == stable_q) begin
            cnt_d    = '0;
        end else if (tick_i) begin
            // >= rather than == so a threshold lowered below the count still accepts.
            if (cnt_inc >= {1'b0, eff_thr_i}) begin
                stable_d = sync_b_q;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_inc[CNT_W-1:0];
            end
        end
    end

    // Stable value and stability counter.
    always_ff @(posedge pclk12 or negedge n_reset12) begin
        if (!n_reset12) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pin_o = stable_q;

`ifdef GPIO_PIN_FILTER_GLITCH_FLAG_EN
    logic glitch_seen_q;
    logic glitch_seen_d;
    logic glitch_set;

    // A glitch is a change that started counting but fell back before acceptance;
    // a set in the same cycle as a clear wins.
    always_comb begin
        glitch_set    = filt_en_i && (cnt_q != '0) && (sync_b_q == stable_q);
        glitch_seen_d = glitch_set | (glitch_seen_q & ~glitch_clr_i);
    end

    // Sticky glitch flag register.
    always_ff @(posedge pclk12 or negedge n_reset12) begin
        if (!n_reset12) begin
            glitch_seen_q <= 1'b0;
        end else begin
            glitch_seen_q <= glitch_seen_d;
        end
    end

    assign glitch_seen_o = glitch_seen_q;
`endif

endmodule

// File: rtl/gpio_pin_filter12.sv
// GPIO pad input filter: shared sample-tick prescaler plus WIDTH per-pin filter cells.
// Latency: 3 cycles pad to pin_filt12 when bypassed; filtered pins add eff_thr ticks.
// Backpressure: none; outputs are registered levels. Glitch flag: GPIO_PIN_FILTER_GLITCH_FLAG_EN.
module gpio_pin_filter12
    import gpio_filter_pkg12::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                pclk12,
    input  logic                n_reset12,
    gpio_pin_filter12_if.slave  bus
);
    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic             tick;
    logic [CNT_W-1:0] eff_thr;
    logic [WIDTH-1:0] pin_filt;

    // Tick whenever the count has reached the period; >= keeps a lowered
    // prescale from stranding the counter above it.
    always_comb begin
        tick      = (pre_cnt_q >= bus.prescale12);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // Prescaler counter.
    always_ff @(posedge pclk12 or negedge n_reset12) begin
        if (!n_reset12) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    // Held low during reset even when prescale12 is 0.
    assign bus.tick12 = tick & n_reset12;

    assign eff_thr = CNT_W'(eff_thr_f(32'(bus.threshold12)));

`ifdef GPIO_PIN_FILTER_GLITCH_FLAG_EN
    logic [WIDTH-1:0] glitch_seen;
    assign bus.glitch_seen12 = glitch_seen;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_filter_cell12 #(
            .CNT_W (CNT_W)
        ) u_cell (
            .pclk12        (pclk12),
            .n_reset12     (n_reset12),
            .pad_i         (bus.pad_in12[i]),
            .filt_en_i     (bus.filter_en12[i]),
            .tick_i        (tick),
            .eff_thr_i     (eff_thr),
`ifdef GPIO_PIN_FILTER_GLITCH_FLAG_EN
            .glitch_clr_i  (bus.glitch_clr12),
            .glitch_seen_o (glitch_seen[i]),
`endif
            .pin_o         (pin_filt[i])
        );
    end

    assign bus.pin_filt12 = pin_filt;

endmodule
